// File: rtl/deser_8way.sv
// Serial-to-parallel deserializer: assembles N accepted bits into a word and
// reports the AND/OR reductions of that word alongside it.
module deser_8way #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_bit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_all1,
  output logic                     out_any1,
  output logic [$clog2(N+1)-1:0]   bit_count
);

  localparam int CW = $clog2(N+1);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            all1_q, all1_d;
  logic            any1_q, any1_d;
  logic [CW-1:0]   count_q, count_d;
  logic            accept;
  logic            xfer;

  // Map the running bit index onto an output lane for the configured order.
  function automatic logic [CW-1:0] lane_of(input logic [CW-1:0] idx);
    if (MSB_FIRST) begin
      return CW'(N - 1) - idx;
    end else begin
      return idx;
    end
  endfunction

  // Write one bit into the selected lane; indices outside 0..N-1 never match.
  function automatic logic [N-1:0] put_bit(input logic [N-1:0] word,
                                           input logic [CW-1:0] lane,
                                           input logic          b);
    logic [N-1:0] w;
    w = word;
    for (int i = 0; i < N; i++) begin
      if (lane == CW'(i)) begin
        w[i] = b;
      end else begin
        w[i] = word[i];
      end
    end
    return w;
  endfunction

  // Handshake decode and next-state computation for the COLLECT/FULL machine.
  always_comb begin
    in_ready = !reset && ((state_q == COLLECT) || out_ready);
    accept   = in_valid && in_ready;
    xfer     = valid_q && out_ready;

    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    all1_d   = all1_q;
    any1_d   = any1_q;
    count_d  = count_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          data_d = put_bit(data_q, lane_of(count_q), in_bit);
          if (count_q == CW'(N - 1)) begin
            state_d = FULL;
            valid_d = 1'b1;
            count_d = CW'(N);
            all1_d  = &data_d;
            any1_d  = |data_d;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          state_d = COLLECT;
        end
      end
      FULL: begin
        // A new word may start on the same edge the finished one drains.
        if (xfer) begin
          state_d = COLLECT;
          valid_d = 1'b0;
          if (accept) begin
            data_d  = put_bit(data_q, lane_of(CW'(0)), in_bit);
            count_d = CW'(1);
          end else begin
            count_d = CW'(0);
          end
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = COLLECT;
        valid_d = 1'b0;
        count_d = CW'(0);
      end
    endcase
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      data_q  <= '0;
      valid_q <= 1'b0;
      all1_q  <= 1'b0;
      any1_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      all1_q  <= all1_d;
      any1_q  <= any1_d;
      count_q <= count_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_all1  = all1_q;
  assign out_any1  = any1_q;
  assign bit_count = count_q;

endmodule
